// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: condition-code register, EX-stage jump resolution and
// PC redirect / pipeline flush sequencing.
// Optional feature macro: BRANCH_FLAG_CLEAR_EN (taken conditional jump clears
// the flag it tested at the resolve edge).
module branch_flush_ctrl #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_zf,
  input  logic                alu_cf,
  input  logic                alu_nf,
  input  logic [2:0]          flag_wr,
  input  logic                ex_branch,
  input  logic [1:0]          ex_sel,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                stall,
  input  logic                ccr_save,
  input  logic                ccr_restore,
  output logic [2:0]          ccr,
  output logic                pc_sel,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic                busy
);

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ccr_q, ccr_d;
  logic [2:0] shadow_q, shadow_d;

  logic       taken;
  logic       resolve;
  logic [2:0] clr_mask;
  logic [2:0] alu_flags;

  assign alu_flags = {alu_zf, alu_cf, alu_nf};
  assign ccr       = ccr_q;

  // Branch condition from the registered CCR; resolution only in IDLE, unstalled
  always_comb begin
    taken = 1'b0;
    case (ex_sel)
      2'b00:   taken = ccr_q[2];
      2'b01:   taken = ccr_q[1];
      2'b10:   taken = ccr_q[0];
      default: taken = 1'b1;
    endcase
    resolve = (state_q == ST_IDLE) && ex_branch && taken && !stall;
  end

  // Flag bit cleared by a taken conditional jump (feature-dependent)
  always_comb begin
    clr_mask = '0;
`ifdef BRANCH_FLAG_CLEAR_EN
    if (resolve) begin
      case (ex_sel)
        2'b00:   clr_mask = 3'b100;
        2'b01:   clr_mask = 3'b010;
        2'b10:   clr_mask = 3'b001;
        default: clr_mask = 3'b000;
      endcase
    end
`endif
  end

  // CCR / shadow next value: restore > per-flag write > clear-on-taken
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (ccr_restore) begin
      ccr_d = shadow_q;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (flag_wr[i])
          ccr_d[i] = alu_flags[i];
        else if (clr_mask[i])
          ccr_d[i] = 1'b0;
      end
      if (ccr_save)
        shadow_d = ccr_q;
    end
  end

  // Flush FSM next-state and outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_sel     = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (resolve) begin
          pc_sel     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        busy       = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q <= 4'd1)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_target = pc_sel ? ex_target : '0;

  // State, counter, CCR and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ccr_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed self-checking bench for branch_flush_ctrl (FLUSH_CYCLES = 2).
module tb_branch_flush_ctrl;

  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_zf, alu_cf, alu_nf;
  logic [2:0]    flag_wr;
  logic          ex_branch;
  logic [1:0]    ex_sel;
  logic [PW-1:0] ex_target;
  logic          stall;
  logic          ccr_save, ccr_restore;
  logic [2:0]    ccr;
  logic          pc_sel;
  logic [PW-1:0] pc_target;
  logic          flush_ifid, flush_idex, busy;

  int vectors = 0;
  int miscompares = 0;

  branch_flush_ctrl #(
    .PC_WIDTH    (PW),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_zf     (alu_zf),
    .alu_cf     (alu_cf),
    .alu_nf     (alu_nf),
    .flag_wr    (flag_wr),
    .ex_branch  (ex_branch),
    .ex_sel     (ex_sel),
    .ex_target  (ex_target),
    .stall      (stall),
    .ccr_save   (ccr_save),
    .ccr_restore(ccr_restore),
    .ccr        (ccr),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, away from both clock edges
  task automatic chk_outs(input string tag, input logic ps, input logic [PW-1:0] pt,
                          input logic fl, input logic bz);
    #3;
    chk({tag, ".pc_sel"},    PW'(pc_sel),     PW'(ps));
    chk({tag, ".pc_target"}, pc_target,       pt);
    chk({tag, ".flush_ifid"},PW'(flush_ifid), PW'(fl));
    chk({tag, ".flush_idex"},PW'(flush_idex), PW'(fl));
    chk({tag, ".busy"},      PW'(busy),       PW'(bz));
  endtask

  task automatic set_flags(input logic [2:0] wr, input logic z, input logic c, input logic n);
    flag_wr = wr; alu_zf = z; alu_cf = c; alu_nf = n;
  endtask

  initial begin
    rst = 1'b1; set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ex_branch = 1'b0; ex_sel = 2'b00; ex_target = '0; stall = 1'b0;
    ccr_save = 1'b0; ccr_restore = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.ccr", PW'(ccr), PW'(3'b000));
    chk_outs("reset", 1'b0, '0, 1'b0, 1'b0);

    // Flag write, then synchronous reset clears CCR
    tick();
    set_flags(3'b111, 1'b1, 1'b0, 1'b1);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    #3 chk("flagwr.ccr", PW'(ccr), PW'(3'b101));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3 chk("rst.ccr", PW'(ccr), PW'(3'b000));

    // JZ taken with zf=1, two-cycle flush
    tick();
    set_flags(3'b100, 1'b1, 1'b0, 1'b0);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ex_branch = 1'b1; ex_sel = 2'b00; ex_target = 32'h40;
    chk_outs("jz.resolve", 1'b1, 32'h40, 1'b1, 1'b0);
    chk("jz.ccr_pre", PW'(ccr), PW'(3'b100));
    tick();
    ex_branch = 1'b0;
    chk_outs("jz.flush1", 1'b0, '0, 1'b1, 1'b1);
    tick();
    chk_outs("jz.done", 1'b0, '0, 1'b0, 1'b0);
`ifdef BRANCH_FLAG_CLEAR_EN
    chk("jz.ccr_after", PW'(ccr), PW'(3'b000));
`else
    chk("jz.ccr_after", PW'(ccr), PW'(3'b100));
`endif

    // JC not taken with cf=0, then JMP always taken
    set_flags(3'b111, 1'b0, 1'b0, 1'b0);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ex_branch = 1'b1; ex_sel = 2'b01; ex_target = 32'h55;
    chk_outs("jc.nt", 1'b0, '0, 1'b0, 1'b0);
    tick();
    ex_sel = 2'b11; ex_target = 32'h80;
    chk_outs("jmp.resolve", 1'b1, 32'h80, 1'b1, 1'b0);
    tick();
    ex_branch = 1'b0;
    chk_outs("jmp.flush1", 1'b0, '0, 1'b1, 1'b1);
    tick();

    // JN with nf=1 held off by a two-cycle stall
    set_flags(3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ex_branch = 1'b1; ex_sel = 2'b10; ex_target = 32'h120; stall = 1'b1;
    chk_outs("jn.stall1", 1'b0, '0, 1'b0, 1'b0);
    tick();
    chk_outs("jn.stall2", 1'b0, '0, 1'b0, 1'b0);
    tick();
    stall = 1'b0;
    chk_outs("jn.resolve", 1'b1, 32'h120, 1'b1, 1'b0);
    tick();
    ex_branch = 1'b0;
    chk_outs("jn.flush1", 1'b0, '0, 1'b1, 1'b1);
    tick();

    // Branch during FLUSH is ignored; reset in the 2nd flush cycle
    ex_branch = 1'b1; ex_sel = 2'b11; ex_target = 32'h200;
    chk_outs("b2.resolve", 1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    ex_target = 32'h300; rst = 1'b1;
    chk_outs("b2.ignored", 1'b0, '0, 1'b1, 1'b1);
    tick();
    rst = 1'b0; ex_branch = 1'b0;
    chk_outs("b2.after_rst", 1'b0, '0, 1'b0, 1'b0);
    chk("b2.ccr_rst", PW'(ccr), PW'(3'b000));

    // Save 011, overwrite with 100, restore together with flag_wr
    set_flags(3'b111, 1'b0, 1'b1, 1'b1);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ccr_save = 1'b1;
    #3 chk("sv.ccr", PW'(ccr), PW'(3'b011));
    tick();
    ccr_save = 1'b0;
    set_flags(3'b111, 1'b1, 1'b0, 1'b0);
    tick();
    #3 chk("sv.overwrite", PW'(ccr), PW'(3'b100));
    ccr_restore = 1'b1;
    set_flags(3'b111, 1'b1, 1'b1, 1'b1);
    tick();
    ccr_restore = 1'b0;
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    #3 chk("restore.wins", PW'(ccr), PW'(3'b011));

    // Restore in the resolve cycle: branch sees pre-restore zf=1
    set_flags(3'b111, 1'b1, 1'b0, 1'b0);
    tick();
    set_flags(3'b000, 1'b0, 1'b0, 1'b0);
    ex_branch = 1'b1; ex_sel = 2'b00; ex_target = 32'h44; ccr_restore = 1'b1;
    chk_outs("rr.resolve", 1'b1, 32'h44, 1'b1, 1'b0);
    tick();
    ex_branch = 1'b0; ccr_restore = 1'b0;
    chk_outs("rr.flush1", 1'b0, '0, 1'b1, 1'b1);
    chk("rr.ccr", PW'(ccr), PW'(3'b011));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
